// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
// XLEN fixes the entry field width; instantiate instruction_fetch with DWIDTH == XLEN.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at request time, filled by responses and
// retired to decode, each through its own wrapping pointer.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DWIDTH = XLEN,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = ptr_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              alloc_i,
  input  logic [DWIDTH-1:0] alloc_pc_i,
  input  logic              fill_i,
  input  logic [DWIDTH-1:0] fill_data_i,
  input  logic              retire_i,
  output logic [PtrW:0]     count_o,
  output logic [PtrW:0]     unfilled_o,
  output logic              head_valid_o,
  output logic [DWIDTH-1:0] head_instr_o,
  output logic [DWIDTH-1:0] head_pc_o
);

  fetch_entry_t    entry_q [DEPTH];
  fetch_entry_t    entry_d [DEPTH];
  logic [PtrW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PtrW-1:0] fill_ptr_q, fill_ptr_d;
  logic [PtrW-1:0] head_ptr_q, head_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [PtrW:0]   unfilled_q, unfilled_d;

  always_comb begin
    entry_d     = entry_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    unfilled_d  = unfilled_q;
    if (clear_i) begin
      // Clear wins over any same-cycle allocate, fill or retire.
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      unfilled_d  = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_d[i].filled = 1'b0;
      end
    end else begin
      if (alloc_i) begin
        entry_d[alloc_ptr_q].pc     = alloc_pc_i;
        entry_d[alloc_ptr_q].instr  = '0;
        entry_d[alloc_ptr_q].filled = 1'b0;
        alloc_ptr_d                 = alloc_ptr_q + PtrW'(1);
      end
      if (fill_i) begin
        entry_d[fill_ptr_q].instr  = fill_data_i;
        entry_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d                 = fill_ptr_q + PtrW'(1);
      end
      if (retire_i) begin
        head_ptr_d = head_ptr_q + PtrW'(1);
      end
      count_d    = count_q + (PtrW+1)'(alloc_i) - (PtrW+1)'(retire_i);
      unfilled_d = unfilled_q + (PtrW+1)'(alloc_i) - (PtrW+1)'(fill_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      unfilled_q  <= unfilled_d;
      entry_q     <= entry_d;
    end
  end

  assign count_o      = count_q;
  assign unfilled_o   = unfilled_q;
  assign head_valid_o = (count_q != '0) && entry_q[head_ptr_q].filled;
  assign head_instr_o = entry_q[head_ptr_q].instr;
  assign head_pc_o    = entry_q[head_ptr_q].pc;

  a_fill_allocated: assert property (@(posedge clk_i) disable iff (rst_i)
    (fill_i && !clear_i) |-> (unfilled_q != '0));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order word fetches at the current PC, tracks responses owed to
// flushed requests, and hands PC-tagged instructions to decode.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned DWIDTH = XLEN,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic [DWIDTH-1:0] Program_Count,
  input  logic              Flush,
  output logic              Run,
  output logic              Imem_Req_Valid,
  input  logic              Imem_Req_Ready,
  output logic [DWIDTH-1:0] Imem_Req_Addr,
  input  logic              Imem_Resp_Valid,
  input  logic [DWIDTH-1:0] Imem_Resp_Data,
  output logic              Instr_Valid,
  input  logic              Instr_Ready,
  output logic [DWIDTH-1:0] Instr,
  output logic [DWIDTH-1:0] Instr_PC
);

  localparam int unsigned PtrW = ptr_w(DEPTH);

  logic [PtrW:0]     count;
  logic [PtrW:0]     unfilled;
  logic [PtrW:0]     drop_q, drop_d;
  logic [PtrW:0]     flush_drop;
  logic [PtrW+1:0]   occupancy;
  logic              accept;
  logic              fill;
  logic              retire;
  logic              head_valid;
  logic [DWIDTH-1:0] head_instr;
  logic [DWIDTH-1:0] head_pc;

  // Responses still owed to dropped requests reserve slots just like live entries.
  assign occupancy      = {1'b0, count} + {1'b0, drop_q};
  assign Imem_Req_Valid = !Rst_Core && !Flush && (occupancy < (PtrW+2)'(DEPTH));
  assign Imem_Req_Addr  = Program_Count;
  assign accept         = Imem_Req_Valid && Imem_Req_Ready;
  assign Run            = accept;

  assign fill   = Imem_Resp_Valid && (drop_q == '0) && (unfilled != '0);
  assign retire = Instr_Valid && Instr_Ready;

  always_comb begin
    drop_d     = drop_q;
    flush_drop = drop_q + unfilled;
    if (Flush) begin
      drop_d = flush_drop;
      if (Imem_Resp_Valid && (flush_drop != '0)) begin
        drop_d = flush_drop - (PtrW+1)'(1);
      end
    end else if (Imem_Resp_Valid && (drop_q != '0)) begin
      drop_d = drop_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  fetch_queue #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fetch_queue (
    .clk_i        (Clk_Core),
    .rst_i        (Rst_Core),
    .clear_i      (Flush),
    .alloc_i      (accept),
    .alloc_pc_i   (Program_Count),
    .fill_i       (fill),
    .fill_data_i  (Imem_Resp_Data),
    .retire_i     (retire),
    .count_o      (count),
    .unfilled_o   (unfilled),
    .head_valid_o (head_valid),
    .head_instr_o (head_instr),
    .head_pc_o    (head_pc)
  );

  assign Instr_Valid = !Rst_Core && head_valid;
  assign Instr       = Instr_Valid ? head_instr : '0;
  assign Instr_PC    = Instr_Valid ? head_pc : '0;

  a_drop_bound: assert property (@(posedge Clk_Core) disable iff (Rst_Core)
    drop_q <= (PtrW+1)'(DEPTH));

  a_resp_expected: assert property (@(posedge Clk_Core) disable iff (Rst_Core)
    Imem_Resp_Valid |-> ((drop_q != '0) || (unfilled != '0)));

  a_addr_stable: assert property (@(posedge Clk_Core) disable iff (Rst_Core)
    (Imem_Req_Valid && !Imem_Req_Ready) |=> $stable(Imem_Req_Addr));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC-stage model and a fixed-latency memory.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q;
  logic        flush;
  logic        run;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        iv;
  logic        ir;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  logic [31:0] reset_pc;
  logic [31:0] flush_target;
  int          lat;

  logic [7:0]  sv;
  logic [31:0] sd [8];
  logic [31:0] acc_q [$];
  logic [31:0] ret_pc_q [$];
  logic [31:0] ret_data_q [$];

  always #5 clk = ~clk;

  instruction_fetch #(
    .DWIDTH (32),
    .DEPTH  (4)
  ) dut (
    .Clk_Core        (clk),
    .Rst_Core        (rst),
    .Program_Count   (pc_q),
    .Flush           (flush),
    .Run             (run),
    .Imem_Req_Valid  (req_valid),
    .Imem_Req_Ready  (req_ready),
    .Imem_Req_Addr   (req_addr),
    .Imem_Resp_Valid (resp_valid),
    .Imem_Resp_Data  (resp_data),
    .Instr_Valid     (iv),
    .Instr_Ready     (ir),
    .Instr           (instr),
    .Instr_PC        (instr_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // PC stage
  always @(posedge clk) begin
    if (rst) pc_q <= reset_pc;
    else if (flush) pc_q <= flush_target;
    else if (run) pc_q <= pc_q + 32'd4;
  end

  // Fixed-latency in-order memory, reset alongside the DUT
  always @(posedge clk) begin
    if (rst) begin
      sv <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        sv[i] <= sv[i+1];
        sd[i] <= sd[i+1];
      end
      sv[7] <= 1'b0;
      if (req_valid && req_ready) begin
        sv[lat-1] <= 1'b1;
        sd[lat-1] <= mem_word(req_addr);
      end
    end
  end
  assign resp_valid = sv[0];
  assign resp_data  = sd[0];

  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) acc_q.push_back(req_addr);
    if (!rst && !flush && iv && ir) begin
      ret_pc_q.push_back(instr_pc);
      ret_data_q.push_back(instr);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; req_ready = 1'b1; ir = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_pc = 32'h0; lat = 1;
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; req_ready = 1'b1; ir = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({req_valid, run, iv} !== 3'b000)
        begin fails++; $display("FAIL reset_ctl cyc %0d: got %b want 000", k, {req_valid, run, iv}); end
      checks++;
      if (instr !== 32'h0 || instr_pc !== 32'h0)
        begin fails++; $display("FAIL reset_data: got %h/%h want 0/0", instr, instr_pc); end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0)
      begin fails++; $display("FAIL reset_release: got %b/%h want 1/0", req_valid, req_addr); end
  endtask

  task automatic test_stream();
    reset_pc = 32'h0; lat = 1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (run !== 1'b1 || req_addr !== 32'(4 * k))
        begin fails++; $display("FAIL stream_req cyc %0d: got %b/%h want 1/%h", k, run, req_addr, 4 * k); end
      checks++;
      if (k >= 2) begin
        if (iv !== 1'b1 || instr_pc !== 32'(4 * (k - 2)) || instr !== mem_word(32'(4 * (k - 2))))
          begin fails++; $display("FAIL stream_out cyc %0d: got %b/%h/%h", k, iv, instr_pc, instr); end
      end else if (iv !== 1'b0) begin
        fails++; $display("FAIL stream_fill cyc %0d: got %b want 0", k, iv);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int ab, rb;
    reset_pc = 32'h0; lat = 1;
    do_reset();
    ir = 1'b0;
    ab = acc_q.size(); rb = ret_pc_q.size();
    for (int k = 0; k < 7; k++) begin
      #1;
      if (k >= 4) begin
        checks++;
        if (req_valid !== 1'b0 || run !== 1'b0)
          begin fails++; $display("FAIL full_hold cyc %0d: got %b/%b want 0/0", k, req_valid, run); end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (acc_q.size() - ab != 4 || pc_q !== 32'h10)
      begin fails++; $display("FAIL full_count: got %0d/%h want 4/10", acc_q.size() - ab, pc_q); end
    checks++;
    if (iv !== 1'b1 || instr_pc !== 32'h0)
      begin fails++; $display("FAIL full_head: got %b/%h want 1/0", iv, instr_pc); end
    ir = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h10)
      begin fails++; $display("FAIL resume_req: got %b/%h want 1/10", req_valid, req_addr); end
    for (int k = 0; k < 6; k++) @(negedge clk);
    checks++;
    if (ret_pc_q.size() < rb + 4 || acc_q.size() < ab + 5) begin
      fails++; $display("FAIL drain_len: got %0d/%0d", ret_pc_q.size() - rb, acc_q.size() - ab);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ret_pc_q[rb+i] !== 32'(4 * i) || ret_data_q[rb+i] !== mem_word(32'(4 * i)))
          begin fails++; $display("FAIL drain_%0d: got %h/%h", i, ret_pc_q[rb+i], ret_data_q[rb+i]); end
      end
      checks++;
      if (acc_q[ab+4] !== 32'h10)
        begin fails++; $display("FAIL resume_addr: got %h want 10", acc_q[ab+4]); end
    end
  endtask

  task automatic test_req_toggle();
    int ab;
    logic [31:0] exp_addr;
    reset_pc = 32'h0; lat = 1;
    do_reset();
    ab = acc_q.size();
    exp_addr = 32'h0;
    for (int k = 0; k < 8; k++) begin
      req_ready = (k % 2 == 0);
      #1;
      checks++;
      if (req_valid !== 1'b1 || run !== req_ready || req_addr !== exp_addr)
        begin fails++; $display("FAIL toggle cyc %0d: got %b/%b/%h want 1/%b/%h", k, req_valid, run, req_addr, req_ready, exp_addr); end
      if (req_ready) exp_addr = exp_addr + 32'd4;
      @(negedge clk);
    end
    req_ready = 1'b1;
    checks++;
    if (acc_q.size() - ab != 4) begin
      fails++; $display("FAIL toggle_count: got %0d want 4", acc_q.size() - ab);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_q[ab+i] !== 32'(4 * i))
          begin fails++; $display("FAIL toggle_seq_%0d: got %h want %h", i, acc_q[ab+i], 4 * i); end
      end
    end
  endtask

  task automatic test_flush_redirect();
    int rb;
    reset_pc = 32'h20; flush_target = 32'h100; lat = 3;
    do_reset();
    rb = ret_pc_q.size();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (run !== 1'b1 || req_addr !== 32'h20 + 32'(4 * k))
        begin fails++; $display("FAIL redir_issue cyc %0d: got %b/%h", k, run, req_addr); end
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (req_valid !== 1'b0 || run !== 1'b0)
      begin fails++; $display("FAIL redir_flush_cyc: got %b/%b want 0/0", req_valid, run); end
    @(negedge clk);
    flush = 1'b0;
    for (int k = 4; k < 8; k++) begin
      #1;
      checks++;
      if (iv !== 1'b0)
        begin fails++; $display("FAIL redir_stale cyc %0d: got %b/%h want 0", k, iv, instr_pc); end
      @(negedge clk);
    end
    #1;
    checks++;
    if (iv !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'hC0DE_0100)
      begin fails++; $display("FAIL redir_first: got %b/%h/%h want 1/100/c0de0100", iv, instr_pc, instr); end
    checks++;
    if (ret_pc_q.size() != rb)
      begin fails++; $display("FAIL redir_retired: got %0d want 0", ret_pc_q.size() - rb); end
    @(negedge clk);
  endtask

  task automatic test_flush_collision();
    int rb;
    reset_pc = 32'h0; flush_target = 32'h200; lat = 2;
    do_reset();
    rb = ret_pc_q.size();
    for (int k = 0; k < 4; k++) @(negedge clk);
    #1;
    checks++;
    if (iv !== 1'b1 || instr_pc !== 32'h4)
      begin fails++; $display("FAIL coll_pre: got %b/%h want 1/4", iv, instr_pc); end
    flush = 1'b1;
    #1;
    checks++;
    if (req_valid !== 1'b0 || run !== 1'b0 || iv !== 1'b1)
      begin fails++; $display("FAIL coll_flush_cyc: got %b/%b/%b want 0/0/1", req_valid, run, iv); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (iv !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0)
      begin fails++; $display("FAIL coll_empty: got %b/%h/%h want 0/0/0", iv, instr, instr_pc); end
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h200)
      begin fails++; $display("FAIL coll_reissue: got %b/%h want 1/200", req_valid, req_addr); end
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (iv !== 1'b0)
        begin fails++; $display("FAIL coll_stale cyc %0d: got %b/%h want 0", k, iv, instr_pc); end
    end
    @(negedge clk);
    #1;
    checks++;
    if (iv !== 1'b1 || instr_pc !== 32'h200 || instr !== 32'hC0DE_0200)
      begin fails++; $display("FAIL coll_first: got %b/%h/%h want 1/200/c0de0200", iv, instr_pc, instr); end
    checks++;
    if (ret_pc_q.size() != rb + 1) begin
      fails++; $display("FAIL coll_retired: got %0d want 1", ret_pc_q.size() - rb);
    end else if (ret_pc_q[rb] !== 32'h0) begin
      fails++; $display("FAIL coll_retired_pc: got %h want 0", ret_pc_q[rb]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    reset_pc = 32'h0; lat = 1;
    do_reset();
    for (int k = 0; k < 5; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({req_valid, run, iv} !== 3'b000 || instr !== 32'h0 || instr_pc !== 32'h0)
      begin fails++; $display("FAIL mid_reset: got %b/%h/%h want 000/0/0", {req_valid, run, iv}, instr, instr_pc); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (iv !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'(4 * k))
        begin fails++; $display("FAIL mid_restart cyc %0d: got %b/%b/%h", k, iv, req_valid, req_addr); end
      @(negedge clk);
    end
    #1;
    checks++;
    if (iv !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hC0DE_0000)
      begin fails++; $display("FAIL mid_first: got %b/%h/%h want 1/0/c0de0000", iv, instr_pc, instr); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_ready = 1'b0; ir = 1'b0;
    reset_pc = 32'h0; flush_target = 32'h0; lat = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_toggle();
    test_flush_redirect();
    test_flush_collision();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Sits directly downstream of the program counter stage.
- Takes the current program count and issues in-order word fetches to instruction memory over a valid/ready request channel, then collects responses.
- Buffers fetched instructions, tagged with their PC, in a small queue feeding the decode stage over a valid/ready channel.
- Drives Run back to the PC stage so the PC advances only when a fetch is accepted; Flush discards all wrong-path work on a redirect.

Parameters:
- DWIDTH, 32, width of PC, address and instruction words
- DEPTH, 4, fetch queue entries; also the maximum number of outstanding plus buffered fetches (power of 2, ≥2)

Ports:
- Clk_Core  input  1  core clock; all state updates on rising edge
- Rst_Core  input  1  synchronous, active-high reset
- Program_Count  input  DWIDTH  current PC from the PC stage
- Flush  input  1  redirect this cycle (branch/jump taken; PC loads a new target next edge)
- Run  output  1  advance-PC enable to the PC stage
- Imem_Req_Valid  output  1  fetch request valid
- Imem_Req_Ready  input  1  memory accepts request
- Imem_Req_Addr  output  DWIDTH  fetch address
- Imem_Resp_Valid  input  1  response data valid; in order, latency ≥1 cycle, no backpressure
- Imem_Resp_Data  input  DWIDTH  instruction word
- Instr_Valid  output  1  head instruction available to decode
- Instr_Ready  input  1  decode consumes head
- Instr  output  DWIDTH  head instruction
- Instr_PC  output  DWIDTH  PC of head instruction

Behaviour:
- Reset (synchronous, Rst_Core=1 at edge):
  - queue emptied; drop_count=0.
  - Outputs read Imem_Req_Valid=0, Run=0, Instr_Valid=0, Instr=0, Instr_PC=0 throughout reset.
- Queue entry fields: {pc, instr, filled}. An entry is allocated at request acceptance and filled on response. Entries are allocated, filled and retired strictly in order using three pointers: alloc, fill, head.
- Issue condition:
  - Imem_Req_Valid = !Rst_Core & !Flush & (entries + drop_count < DEPTH).
  - Imem_Req_Addr = Program_Count, passed combinationally.
  - A request is accepted when Imem_Req_Valid & Imem_Req_Ready. Acceptance allocates an entry with pc=Program_Count and filled=0.
- Run = request accepted this cycle. The PC stage therefore updates exactly once per accepted fetch; one request per cycle maximum (back-to-back throughput 1/cycle).
- Response handling:
  - Imem_Resp_Valid with drop_count>0: decrement drop_count; data discarded.
  - Imem_Resp_Valid with drop_count=0: write data into the entry at the fill pointer and set filled=1.
  - A response while drop_count=0 and no unfilled entry exists is a protocol error; the simulation assertion fires and the response is ignored.
- Output:
  - Instr_Valid = head entry allocated & filled. Instr and Instr_PC come from the head entry and are zero when Instr_Valid=0.
  - Head retires when Instr_Valid & Instr_Ready.
  - Earliest response-to-output latency is 1 cycle: a registered entry fill, with no response bypass.
- Flush (takes priority over everything in the same cycle):
  - All entries are cleared, including any retire the same cycle.
  - drop_count_next = drop_count + unfilled_entries − (Imem_Resp_Valid ? 1 : 0). The same-cycle response counts against either the old drop_count or an unfilled entry.
  - No request is issued and Run=0 during the Flush cycle.
  - Instr_Valid is still driven combinationally that cycle; decode must ignore it when flushing.
- Simultaneous allocate, fill and retire in one cycle are all legal. The entry count is updated as +alloc −retire.
- Full: entries + drop_count = DEPTH holds Imem_Req_Valid=0 and Run=0; the PC holds.
- Empty: Instr_Valid=0.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. A separate count (log2(DEPTH)+1 bits) distinguishes full from empty.
- Reset mid-operation: outstanding memory responses after reset are not tracked. Memory is reset together with this block, on the same Rst_Core.
- Assertions: drop_count ≤ DEPTH; no fill into a non-allocated entry; Imem_Req_Addr stable while Imem_Req_Valid & !Imem_Req_Ready (PC holds since Run=0).

Decomposition:
- fetch_pkg:
  - fetch_entry_t struct {pc, instr, filled}
  - PTR_W = $clog2(DEPTH) helper
  - NOP constant 32'h0000_0013
- One sub-module, fetch_queue: in-order allocate/fill/retire circular buffer with pointers, count and clear. Top level holds issue control, drop_count and port glue.

Test Plan:
- Zero-wait memory (ready=1, 1-cycle latency), Instr_Ready=1, PC from 0x0 → Instr_PC sequence 0x0, 0x4, 0x8… one per cycle after 2-cycle fill latency; Run=1 every cycle.
- Instr_Ready=0 with DEPTH=4 → exactly 4 requests accepted (0x0–0xC); Imem_Req_Valid and Run drop to 0; PC holds 0x10. Raising Instr_Ready drains 0x0, 0x4, 0x8, 0xC, then issue resumes at 0x10.
- Imem_Req_Ready toggling 1,0,1,0 → Run mirrors acceptance and Imem_Req_Addr stays stable across stalls; no duplicate or skipped PCs.
- 3-cycle memory latency, 3 fetches outstanding (0x20, 0x24, 0x28), Flush with PC redirected to 0x100 → next 3 responses dropped; first Instr_Valid carries Instr_PC=0x100 with its memory data.
- Flush in the same cycle as a response and a head retire → drop_count = unfilled−1; queue empty next cycle; no stale instruction ever presented.
- Rst_Core asserted mid-stream for 1 cycle → all outputs 0 during reset; fetch restarts cleanly from the reset PC with Instr_Valid=0 until the first new response.
